// File: rtl/clk_div_pkg.sv
// Shared defaults, divisor type and helpers for the programmable clock-enable generator.
package clk_div_pkg;

   localparam int DIV_W_DEF    = 8;
   localparam int DIV_RST_DEF  = 2;
   localparam int LOCK_CYC_DEF = 16;

   typedef logic [DIV_W_DEF-1:0] div_t;

   // Number of high cycles in a period of d: ceil(d/2)
   function automatic logic [31:0] half_div(input logic [31:0] d);
      return (d + 32'd1) >> 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor and registered ce/div outputs.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DIV_RST = DIV_RST_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [DIV_W-1:0] wdiv,
   input  logic             sync,
   output logic             apply,
   output logic             ce,
   output logic             div
);

   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] cnt_r, cur_div_r, pend_div_r;
   logic             pend_vld_r, ce_r, div_r;

   logic [DIV_W-1:0] cnt_s, cur_div_s, pend_div_s;
   logic             pend_vld_s, ce_s, div_s;
   logic             idle_s, wrap_s, apply_s;
   logic [DIV_W:0]   half_s;

   // Next-state logic: wrap/idle/sync all restart the period at cnt 0 using the newly applied divisor
   always_comb begin
      idle_s    = (cur_div_r == DIV_ZERO);
      wrap_s    = !idle_s && (cnt_r == (cur_div_r - DIV_ONE));
      apply_s   = pend_vld_r && (sync || wrap_s || idle_s);
      cur_div_s = apply_s ? pend_div_r : cur_div_r;

      if (sync || idle_s || wrap_s) begin
         cnt_s = DIV_ZERO;
      end else begin
         cnt_s = cnt_r + DIV_ONE;
      end

      ce_s   = wrap_s && !sync;
      half_s = (DIV_W+1)'(half_div(32'(cur_div_s)));
      div_s  = ({1'b0, cnt_s} < half_s);

      // A write landing on an apply event is kept for the following event
      if (we) begin
         pend_div_s = wdiv;
         pend_vld_s = 1'b1;
      end else if (apply_s) begin
         pend_div_s = pend_div_r;
         pend_vld_s = 1'b0;
      end else begin
         pend_div_s = pend_div_r;
         pend_vld_s = pend_vld_r;
      end
   end

   // Channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r      <= DIV_ZERO;
         cur_div_r  <= DIV_W'(DIV_RST);
         pend_div_r <= DIV_ZERO;
         pend_vld_r <= 1'b0;
         ce_r       <= 1'b0;
         div_r      <= 1'b0;
      end else begin
         cnt_r      <= cnt_s;
         cur_div_r  <= cur_div_s;
         pend_div_r <= pend_div_s;
         pend_vld_r <= pend_vld_s;
         ce_r       <= ce_s;
         div_r      <= div_s;
      end
   end

   assign apply = apply_s;
   assign ce    = ce_r;
   assign div   = div_r;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel runtime-programmable clock-enable / divided-clock generator with lock indication.
module clk_div_gen
   import clk_div_pkg::*;
#(
   parameter int NUM_CH   = 3,
   parameter int DIV_W    = DIV_W_DEF,
   parameter int DIV_RST  = DIV_RST_DEF,
   parameter int LOCK_CYC = LOCK_CYC_DEF,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clkin,
   input  logic              reset_n,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              sync,
   output logic [NUM_CH-1:0] ce_o,
   output logic [NUM_CH-1:0] div_o,
   output logic              lock
);

   localparam int LK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
   localparam logic [LK_W-1:0] LOCK_MAX = LK_W'(LOCK_CYC - 1);
   localparam logic [LK_W-1:0] LK_ONE   = {{(LK_W-1){1'b0}}, 1'b1};

   logic [NUM_CH-1:0] we_s, apply_s;
   logic              apply_any_s;
   logic [LK_W-1:0]   lock_cnt_r, lock_cnt_s;
   logic              lock_r, lock_s;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Out-of-range channel indices match no channel and are dropped
      assign we_s[i] = cfg_we && (cfg_ch == CH_W'(i));

      clk_div_chan #(
         .DIV_W   (DIV_W),
         .DIV_RST (DIV_RST)
      ) u_chan (
         .clk   (clkin),
         .rst_n (reset_n),
         .we    (we_s[i]),
         .wdiv  (cfg_div),
         .sync  (sync),
         .apply (apply_s[i]),
         .ce    (ce_o[i]),
         .div   (div_o[i])
      );
   end

   assign apply_any_s = |apply_s;

   // Lock counter: restart on any divisor change or sync, saturate at LOCK_CYC-1
   always_comb begin
      if (apply_any_s || sync) begin
         lock_cnt_s = {LK_W{1'b0}};
         lock_s     = 1'b0;
      end else if (lock_cnt_r != LOCK_MAX) begin
         lock_cnt_s = lock_cnt_r + LK_ONE;
         lock_s     = 1'b0;
      end else begin
         lock_cnt_s = lock_cnt_r;
         lock_s     = 1'b1;
      end
   end

   // Lock state registers
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         lock_cnt_r <= {LK_W{1'b0}};
         lock_r     <= 1'b0;
      end else begin
         lock_cnt_r <= lock_cnt_s;
         lock_r     <= lock_s;
      end
   end

   assign lock = lock_r;

endmodule
